// File: rtl/comparator_seq_param.sv
// Digit-serial magnitude comparator: compares two words fed DIGIT_W bits per
// accepted cycle, MSB- or LSB-first, unsigned or two's complement.
module comparator_seq_param #(
  parameter int DIGIT_W   = 1,
  parameter int WORD_LEN  = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               valid,
  input  logic               signed_mode,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               eq,
  output logic               gt,
  output logic               lt,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(WORD_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_LEN - 1);
  localparam logic [CNT_W-1:0] SIGN_IDX = MSB_FIRST ? '0 : LAST_IDX;

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {RES_EQ, RES_GT, RES_LT} res_t;

  state_t             state, state_nxt;
  res_t               res, res_nxt, digit_res;
  logic [CNT_W-1:0]   cnt, cnt_nxt, idx;
  logic               sgn_lat, sgn_nxt, sgn_cur, done_nxt, accept;
  logic [DIGIT_W-1:0] a_adj, b_adj;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      res     <= RES_EQ;
      cnt     <= '0;
      sgn_lat <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      res     <= res_nxt;
      cnt     <= cnt_nxt;
      sgn_lat <= sgn_nxt;
      done    <= done_nxt;
    end
  end

  // A start restarts the word and may also carry its digit 0 in the same cycle,
  // so the digit index, sign mode and base result are taken from the restarted
  // context whenever start is high.
  always_comb begin
    state_nxt = state;
    res_nxt   = res;
    cnt_nxt   = cnt;
    sgn_nxt   = sgn_lat;
    done_nxt  = 1'b0;

    accept  = valid && (start || (state == RUN));
    idx     = start ? '0 : cnt;
    sgn_cur = start ? signed_mode : sgn_lat;

    a_adj = a;
    b_adj = b;
    if (sgn_cur && (idx == SIGN_IDX)) begin
      a_adj[DIGIT_W-1] = ~a[DIGIT_W-1];
      b_adj[DIGIT_W-1] = ~b[DIGIT_W-1];
    end

    if (a_adj > b_adj)      digit_res = RES_GT;
    else if (a_adj < b_adj) digit_res = RES_LT;
    else                    digit_res = RES_EQ;

    if (start) begin
      state_nxt = RUN;
      res_nxt   = RES_EQ;
      cnt_nxt   = '0;
      sgn_nxt   = signed_mode;
    end

    // MSB-first locks on the first difference; LSB-first lets later digits win.
    if (accept) begin
      if ((digit_res != RES_EQ) && (!MSB_FIRST || (res_nxt == RES_EQ)))
        res_nxt = digit_res;
      if (idx == LAST_IDX) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = RUN;
        cnt_nxt   = idx + CNT_W'(1);
      end
    end
  end

  assign eq   = (res == RES_EQ);
  assign gt   = (res == RES_GT);
  assign lt   = (res == RES_LT);
  assign busy = (state == RUN);

endmodule

// File: tb/tb_comparator_seq_param.sv
// Scoreboard bench for comparator_seq_param: two instances (1x4 MSB-first and
// 2x2 LSB-first) checked each cycle against a word-level arithmetic model.
module tb_comparator_seq_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, valid, signed_mode;
  logic       a0, b0;
  logic [1:0] a1, b1;
  logic       eq0, gt0, lt0, busy0, done0;
  logic       eq1, gt1, lt1, busy1, done1;

  comparator_seq_param #(.DIGIT_W(1), .WORD_LEN(4), .MSB_FIRST(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .valid(valid),
    .signed_mode(signed_mode), .a(a0), .b(b0),
    .eq(eq0), .gt(gt0), .lt(lt0), .busy(busy0), .done(done0)
  );

  comparator_seq_param #(.DIGIT_W(2), .WORD_LEN(2), .MSB_FIRST(0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .valid(valid),
    .signed_mode(signed_mode), .a(a1), .b(b1),
    .eq(eq1), .gt(gt1), .lt(lt1), .busy(busy1), .done(done1)
  );

  // Model: each word is accumulated as an integer and the running result is
  // the numeric comparison of the digits received so far.
  bit     m_active[2];
  int     m_k[2];
  longint m_pa[2], m_pb[2];
  bit     m_sgn[2];
  int     m_res[2];
  bit     m_done[2];

  logic [4:0] q0[$];
  logic [4:0] q1[$];
  int    checks = 0;
  int    failures = 0;
  string phase = "reset";

  function automatic int cmp_words(longint pa, longint pb, int n, bit sgnd);
    longint va = pa;
    longint vb = pb;
    if (sgnd) begin
      if (pa >= (longint'(1) << (n - 1))) va = pa - (longint'(1) << n);
      if (pb >= (longint'(1) << (n - 1))) vb = pb - (longint'(1) << n);
    end
    return (va > vb) ? 1 : ((va < vb) ? 2 : 0);
  endfunction

  function automatic logic [4:0] model_step(int i, int dw, int wl, bit msb,
                                            bit r, bit s, bit v, bit sm,
                                            longint da, longint db);
    if (r) begin
      m_active[i] = 0; m_k[i] = 0; m_pa[i] = 0; m_pb[i] = 0;
      m_sgn[i] = 0; m_res[i] = 0; m_done[i] = 0;
    end else begin
      m_done[i] = 0;
      if (s) begin
        m_active[i] = 1; m_k[i] = 0; m_pa[i] = 0; m_pb[i] = 0;
        m_sgn[i] = sm; m_res[i] = 0;
      end
      if (v && m_active[i]) begin
        if (msb) begin
          m_pa[i] = (m_pa[i] << dw) + da;
          m_pb[i] = (m_pb[i] << dw) + db;
        end else begin
          m_pa[i] = m_pa[i] + (da << (m_k[i] * dw));
          m_pb[i] = m_pb[i] + (db << (m_k[i] * dw));
        end
        m_k[i]++;
        m_res[i] = cmp_words(m_pa[i], m_pb[i], m_k[i] * dw,
                             m_sgn[i] && (msb || (m_k[i] == wl)));
        if (m_k[i] == wl) begin
          m_active[i] = 0; m_k[i] = 0; m_done[i] = 1;
        end
      end
    end
    return {m_res[i] == 0, m_res[i] == 1, m_res[i] == 2, m_active[i], m_done[i]};
  endfunction

  task automatic step(bit r, bit s, bit v, bit sm,
                      logic da0, logic db0, logic [1:0] da1, logic [1:0] db1);
    logic [4:0] e0, e1;
    reset = r; start = s; valid = v; signed_mode = sm;
    a0 = da0; b0 = db0; a1 = da1; b1 = db1;
    e0 = model_step(0, 1, 4, 1'b1, r, s, v, sm, longint'(da0), longint'(db0));
    e1 = model_step(1, 2, 2, 1'b0, r, s, v, sm, longint'(da1), longint'(db1));
    @(posedge clk);
    q0.push_back(e0);
    q1.push_back(e1);
    #1;
  endtask

  // One word on each instance: dut0 takes 4 single-bit digits MSB-first,
  // dut1 takes 2 two-bit digits LSB-first; extra digits hit dut1 while idle.
  task automatic apply_stimulus(logic [3:0] wa0, logic [3:0] wb0,
                                logic [3:0] wa1, logic [3:0] wb1,
                                bit sm, int gap);
    logic [1:0] d1a, d1b;
    for (int i = 0; i < 4; i++) begin
      d1a = (i < 2) ? wa1[2*i +: 2] : 2'b00;
      d1b = (i < 2) ? wb1[2*i +: 2] : 2'b00;
      step(1'b0, i == 0, 1'b1, sm, wa0[3-i], wb0[3-i], d1a, d1b);
      for (int g = 0; g < gap; g++)
        step(1'b0, 1'b0, 1'b0, sm, 1'($urandom), 1'($urandom),
             2'($urandom), 2'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, sm, 1'b0, 1'b0, 2'b00, 2'b00);
    step(1'b0, 1'b0, 1'b0, sm, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  always @(negedge clk) begin
    logic [4:0] exp_v, got_v;
    if (q0.size() > 0) begin
      exp_v = q0.pop_front();
      got_v = {eq0, gt0, lt0, busy0, done0};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL %s dut0 eq/gt/lt/busy/done got=%b expected=%b at %0t",
                 phase, got_v, exp_v, $time);
      end
    end
    if (q1.size() > 0) begin
      exp_v = q1.pop_front();
      got_v = {eq1, gt1, lt1, busy1, done1};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL %s dut1 eq/gt/lt/busy/done got=%b expected=%b at %0t",
                 phase, got_v, exp_v, $time);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; valid = 1'b0; signed_mode = 1'b0;
    a0 = 1'b0; b0 = 1'b0; a1 = 2'b00; b1 = 2'b00;

    phase = "reset";
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00);

    phase = "unsigned_msb";
    apply_stimulus(4'b0110, 4'b1100, 4'b1001, 4'b0110, 1'b0, 0);
    phase = "signed_msb";
    apply_stimulus(4'b0110, 4'b1100, 4'b1001, 4'b0110, 1'b1, 0);
    phase = "equal_gaps";
    apply_stimulus(4'b1010, 4'b1010, 4'b1010, 4'b1010, 1'b0, 3);

    phase = "reset_midword";
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 2'b00);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00);
    apply_stimulus(4'b1011, 4'b1001, 4'b0111, 4'b1000, 1'b0, 0);

    phase = "start_restart";
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 2'b11);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    phase = "random";
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1, 1'($urandom),
           1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));

    phase = "drain";
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain queue_left got=%0d/%0d expected=0/0",
               q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
